// File: rtl/dmem_port_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_port_ctrl
//
// Data-memory port controller for port B of the core's byte-writable block RAM.
// Two requesters share the port: the core load/store unit and the word-oriented
// program loader. One transaction is in flight at a time and it walks
// IDLE -> ISSUE -> RESP -> IDLE, giving one access every three cycles.
//
// Core accesses are translated from RV32 load/store semantics (funct3 plus byte
// address) into a word address, byte-lane write enables and lane-replicated
// write data. Load data is lane-selected and sign/zero extended in RESP.
// Illegal funct3, misaligned and out-of-range core accesses still take the
// 3-cycle path but never enable the RAM, and answer with an error response.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   i_core_req_*/o_core_*  core request (valid/ready, we, funct3, addr, wdata)
//                          and response (valid strobe, err, formatted rdata)
//   i_ldr_req_*/o_ldr_*    loader request (valid/ready, we, word addr, wdata,
//                          wstrb) and response (valid strobe, raw rdata)
//   o_ram_*, i_ram_dout    RAM port B; read data is registered, read-first,
//                          one cycle after the enabled edge
// -----------------------------------------------------------------------------
module dmem_port_ctrl #(
  parameter int unsigned ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  // Core requester
  input  logic                  i_core_req_valid,
  output logic                  o_core_req_ready,
  input  logic                  i_core_we,
  input  logic [2:0]            i_core_funct3,
  input  logic [31:0]           i_core_addr,
  input  logic [31:0]           i_core_wdata,
  output logic                  o_core_rsp_valid,
  output logic                  o_core_rsp_err,
  output logic [31:0]           o_core_rdata,
  // Loader requester
  input  logic                  i_ldr_req_valid,
  output logic                  o_ldr_req_ready,
  input  logic                  i_ldr_we,
  input  logic [ADDR_WIDTH-1:0] i_ldr_addr,
  input  logic [31:0]           i_ldr_wdata,
  input  logic [3:0]            i_ldr_wstrb,
  output logic                  o_ldr_rsp_valid,
  output logic [31:0]           o_ldr_rdata,
  // RAM port B
  output logic                  o_ram_en,
  output logic [3:0]            o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [31:0]           o_ram_din,
  input  logic [31:0]           i_ram_dout
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StResp  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State and captured request
  // ---------------------------------------------------------------------------
  state_t                r_state;
  logic                  r_last_core;    // 1 = core held the most recent grant
  logic                  r_is_core;      // current transaction belongs to core
  logic                  r_we;
  logic                  r_err;
  logic [2:0]            r_funct3;
  logic [1:0]            r_lane;         // core byte offset within the word
  logic                  r_ram_en;
  logic [3:0]            r_ram_we;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [31:0]           r_ram_din;
  logic                  r_core_rsp_valid;
  logic                  r_ldr_rsp_valid;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic w_idle;
  logic w_grant_core;
  logic w_grant_ldr;
  logic w_core_hs;
  logic w_ldr_hs;

  always_comb begin
    w_idle       = (r_state == StIdle) && !rst;
    // On a tie the requester that did not win last time goes first.
    w_grant_core = i_core_req_valid && (!i_ldr_req_valid || !r_last_core);
    w_grant_ldr  = i_ldr_req_valid && !w_grant_core;
    w_core_hs    = w_idle && w_grant_core;
    w_ldr_hs     = w_idle && w_grant_ldr;
  end

  assign o_core_req_ready = w_core_hs;
  assign o_ldr_req_ready  = w_ldr_hs;

  // ---------------------------------------------------------------------------
  // Core request decode: error check, lane enables, replicated store data
  // ---------------------------------------------------------------------------
  logic                  w_illegal;
  logic                  w_misaligned;
  logic                  w_out_of_range;
  logic                  w_core_err;
  logic [3:0]            w_core_lanes;
  logic [31:0]           w_core_din;
  logic [ADDR_WIDTH-1:0] w_core_waddr;

  always_comb begin
    w_illegal = 1'b0;
    if (i_core_we) begin
      w_illegal = (i_core_funct3 > 3'b010);
    end else begin
      w_illegal = (i_core_funct3 == 3'b011) || (i_core_funct3 == 3'b110) ||
                  (i_core_funct3 == 3'b111);
    end

    w_misaligned = ((i_core_funct3[1:0] == 2'b01) && i_core_addr[0]) ||
                   ((i_core_funct3[1:0] == 2'b10) && (i_core_addr[1:0] != 2'b00));

    // Any byte address beyond the RAM's 4 * 2**ADDR_WIDTH bytes is rejected.
    w_out_of_range = ((i_core_addr >> (ADDR_WIDTH + 2)) != 32'd0);

    w_core_err = w_illegal || w_misaligned || w_out_of_range;
  end

  always_comb begin
    w_core_lanes = 4'b0000;
    w_core_din   = 32'd0;
    unique case (i_core_funct3[1:0])
      2'b00: begin
        w_core_lanes = 4'b0001 << i_core_addr[1:0];
        w_core_din   = {4{i_core_wdata[7:0]}};
      end
      2'b01: begin
        w_core_lanes = i_core_addr[1] ? 4'b1100 : 4'b0011;
        w_core_din   = {2{i_core_wdata[15:0]}};
      end
      default: begin
        w_core_lanes = 4'b1111;
        w_core_din   = i_core_wdata;
      end
    endcase
  end

  assign w_core_waddr = i_core_addr[ADDR_WIDTH+1:2];

  // ---------------------------------------------------------------------------
  // Load data formatting (RESP cycle, straight from the RAM output register)
  // ---------------------------------------------------------------------------
  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_fmt;

  always_comb begin
    w_shifted  = i_ram_dout >> {r_lane, 3'b000};
    w_byte     = w_shifted[7:0];
    w_half     = r_lane[1] ? i_ram_dout[31:16] : i_ram_dout[15:0];
    w_load_fmt = i_ram_dout;
    unique case (r_funct3)
      3'b000:  w_load_fmt = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_fmt = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_fmt = {24'd0, w_byte};
      3'b101:  w_load_fmt = {16'd0, w_half};
      default: w_load_fmt = i_ram_dout;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM with registered RAM controls and response strobes
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= StIdle;
      r_last_core      <= 1'b0;
      r_is_core        <= 1'b0;
      r_we             <= 1'b0;
      r_err            <= 1'b0;
      r_funct3         <= 3'd0;
      r_lane           <= 2'd0;
      r_ram_en         <= 1'b0;
      r_ram_we         <= 4'd0;
      r_ram_addr       <= '0;
      r_ram_din        <= 32'd0;
      r_core_rsp_valid <= 1'b0;
      r_ldr_rsp_valid  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_core_hs) begin
            r_state     <= StIssue;
            r_last_core <= 1'b1;
            r_is_core   <= 1'b1;
            r_we        <= i_core_we;
            r_err       <= w_core_err;
            r_funct3    <= i_core_funct3;
            r_lane      <= i_core_addr[1:0];
            // Rejected accesses keep the RAM port completely quiet.
            r_ram_en    <= !w_core_err;
            r_ram_we    <= (!w_core_err && i_core_we) ? w_core_lanes : 4'd0;
            r_ram_addr  <= w_core_err ? '0 : w_core_waddr;
            r_ram_din   <= (!w_core_err && i_core_we) ? w_core_din : 32'd0;
          end else if (w_ldr_hs) begin
            r_state     <= StIssue;
            r_last_core <= 1'b0;
            r_is_core   <= 1'b0;
            r_we        <= i_ldr_we;
            r_err       <= 1'b0;
            r_funct3    <= 3'd0;
            r_lane      <= 2'd0;
            r_ram_en    <= 1'b1;
            r_ram_we    <= i_ldr_we ? i_ldr_wstrb : 4'd0;
            r_ram_addr  <= i_ldr_addr;
            r_ram_din   <= i_ldr_we ? i_ldr_wdata : 32'd0;
          end
        end
        StIssue: begin
          r_state          <= StResp;
          r_ram_en         <= 1'b0;
          r_ram_we         <= 4'd0;
          r_ram_addr       <= '0;
          r_ram_din        <= 32'd0;
          r_core_rsp_valid <= r_is_core;
          r_ldr_rsp_valid  <= !r_is_core;
        end
        StResp: begin
          r_state          <= StIdle;
          r_core_rsp_valid <= 1'b0;
          r_ldr_rsp_valid  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. rst gates everything combinationally so that a reset landing in
  // ISSUE cannot produce a partial write and one landing in RESP drops the
  // response.
  // ---------------------------------------------------------------------------
  always_comb begin
    o_ram_en   = r_ram_en && !rst;
    o_ram_we   = rst ? 4'd0 : r_ram_we;
    o_ram_addr = rst ? '0 : r_ram_addr;
    o_ram_din  = rst ? 32'd0 : r_ram_din;

    o_core_rsp_valid = r_core_rsp_valid && !rst;
    o_core_rsp_err   = o_core_rsp_valid && r_err;
    o_core_rdata     = (o_core_rsp_valid && !r_err && !r_we) ? w_load_fmt : 32'd0;

    o_ldr_rsp_valid  = r_ldr_rsp_valid && !rst;
    o_ldr_rdata      = (o_ldr_rsp_valid && !r_we) ? i_ram_dout : 32'd0;
  end

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_port_ctrl
//
// Bench for dmem_port_ctrl. A word RAM with registered read-first output sits
// on the RAM port; a separate byte-addressed memory image predicts every core
// and loader response from the RV32 load/store rules.
// -----------------------------------------------------------------------------
module tb_dmem_port_ctrl;

  localparam int unsigned AW = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_req_valid;
  logic          core_req_ready;
  logic          core_we;
  logic [2:0]    core_funct3;
  logic [31:0]   core_addr;
  logic [31:0]   core_wdata;
  logic          core_rsp_valid;
  logic          core_rsp_err;
  logic [31:0]   core_rdata;
  logic          ldr_req_valid;
  logic          ldr_req_ready;
  logic          ldr_we;
  logic [AW-1:0] ldr_addr;
  logic [31:0]   ldr_wdata;
  logic [3:0]    ldr_wstrb;
  logic          ldr_rsp_valid;
  logic [31:0]   ldr_rdata;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_din;
  logic [31:0]   ram_dout = 32'd0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_port_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_core_req_valid (core_req_valid),
    .o_core_req_ready (core_req_ready),
    .i_core_we        (core_we),
    .i_core_funct3    (core_funct3),
    .i_core_addr      (core_addr),
    .i_core_wdata     (core_wdata),
    .o_core_rsp_valid (core_rsp_valid),
    .o_core_rsp_err   (core_rsp_err),
    .o_core_rdata     (core_rdata),
    .i_ldr_req_valid  (ldr_req_valid),
    .o_ldr_req_ready  (ldr_req_ready),
    .i_ldr_we         (ldr_we),
    .i_ldr_addr       (ldr_addr),
    .i_ldr_wdata      (ldr_wdata),
    .i_ldr_wstrb      (ldr_wstrb),
    .o_ldr_rsp_valid  (ldr_rsp_valid),
    .o_ldr_rdata      (ldr_rdata),
    .o_ram_en         (ram_en),
    .o_ram_we         (ram_we),
    .o_ram_addr       (ram_addr),
    .o_ram_din        (ram_din),
    .i_ram_dout       (ram_dout)
  );

  // Byte-writable RAM, read-first, one-cycle registered read.
  logic [31:0] tb_ram [0:8191] = '{default: 32'h0};
  always @(posedge clk) begin
    if (ram_en) begin
      ram_dout <= tb_ram[ram_addr];
      for (int b = 0; b < 4; b++) begin
        if (ram_we[b]) tb_ram[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
      end
    end
  end

  // Reference memory image, one entry per byte address.
  logic [7:0] ref_bytes [0:32767] = '{default: 8'h00};

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic int unsigned acc_size(input logic [2:0] f3);
    logic [1:0] sz;
    sz = f3[1:0];
    return 32'd1 << sz;
  endfunction

  function automatic logic model_core_err(input logic we, input logic [2:0] f3,
                                          input logic [31:0] addr);
    if (we && f3 > 3'd2) return 1'b1;
    if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
    if ((addr % acc_size(f3)) != 0) return 1'b1;
    if (addr >= 32'h8000) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_word(input int unsigned wa);
    return {ref_bytes[4*wa+3], ref_bytes[4*wa+2], ref_bytes[4*wa+1], ref_bytes[4*wa]};
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned a;
    logic [7:0]  b;
    logic [15:0] h;
    a = addr;
    b = ref_bytes[a];
    h = {ref_bytes[a+1], ref_bytes[a]};
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd4:    return {24'd0, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd5:    return {16'd0, h};
      default: return model_word(a / 4);
    endcase
  endfunction

  function automatic logic [3:0] model_lanes(input logic [2:0] f3, input logic [31:0] addr);
    logic [3:0] l;
    l = 4'd0;
    for (int i = 0; i < int'(acc_size(f3)); i++) l[int'(addr % 4) + i] = 1'b1;
    return l;
  endfunction

  function automatic logic [31:0] model_din(input logic [2:0] f3, input logic [31:0] wdata);
    logic [31:0] d;
    for (int l = 0; l < 4; l++) d[8*l +: 8] = wdata[8*(l % int'(acc_size(f3))) +: 8];
    return d;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata);
    for (int i = 0; i < int'(acc_size(f3)); i++) ref_bytes[addr + i] = wdata[8*i +: 8];
  endtask

  // ---------------------------------------------------------------------------
  // Transactions
  // ---------------------------------------------------------------------------
  task automatic core_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata_o,
                          output logic err_o);
    logic        exp_err;
    logic [31:0] exp_rdata;
    bit          got;
    exp_err   = model_core_err(we, f3, addr);
    exp_rdata = (!exp_err && !we) ? model_load(f3, addr) : 32'd0;
    rdata_o   = 32'd0;
    err_o     = 1'b0;
    @(negedge clk);
    core_we = we; core_funct3 = f3; core_addr = addr; core_wdata = wdata;
    core_req_valid = 1'b1;
    #1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (core_req_ready) begin got = 1; break; end
      @(negedge clk); #1;
    end
    if (!got) begin
      check("core_ready_timeout", 32'd0, 32'd1);
      core_req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    core_req_valid = 1'b0;
    @(negedge clk);  // ISSUE
    check("core_issue_rsp_quiet", 32'(core_rsp_valid), 32'd0);
    check("core_issue_ram_en", 32'(ram_en), 32'(!exp_err));
    if (!exp_err) begin
      check("core_issue_ram_addr", 32'(ram_addr), addr >> 2);
      check("core_issue_ram_we", 32'(ram_we), we ? 32'(model_lanes(f3, addr)) : 32'd0);
      if (we) check("core_issue_ram_din", ram_din, model_din(f3, wdata));
    end
    @(negedge clk);  // RESP
    check("core_rsp_valid", 32'(core_rsp_valid), 32'd1);
    check("core_rsp_err", 32'(core_rsp_err), 32'(exp_err));
    check("core_rdata", core_rdata, exp_rdata);
    check("core_resp_ram_idle", 32'(ram_en), 32'd0);
    rdata_o = core_rdata;
    err_o   = core_rsp_err;
    @(negedge clk);  // back in IDLE
    check("core_rsp_one_cycle", 32'(core_rsp_valid), 32'd0);
    if (!exp_err && we) model_store(f3, addr, wdata);
  endtask

  task automatic ldr_txn(input logic we, input logic [AW-1:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, output logic [31:0] rdata_o);
    logic [31:0] exp_rdata;
    bit          got;
    int unsigned wa;
    wa        = 32'(addr);
    exp_rdata = we ? 32'd0 : model_word(wa);
    rdata_o   = 32'd0;
    @(negedge clk);
    ldr_we = we; ldr_addr = addr; ldr_wdata = wdata; ldr_wstrb = strb;
    ldr_req_valid = 1'b1;
    #1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (ldr_req_ready) begin got = 1; break; end
      @(negedge clk); #1;
    end
    if (!got) begin
      check("ldr_ready_timeout", 32'd0, 32'd1);
      ldr_req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    ldr_req_valid = 1'b0;
    @(negedge clk);  // ISSUE
    check("ldr_issue_rsp_quiet", 32'(ldr_rsp_valid), 32'd0);
    check("ldr_issue_ram_en", 32'(ram_en), 32'd1);
    check("ldr_issue_ram_addr", 32'(ram_addr), wa);
    check("ldr_issue_ram_we", 32'(ram_we), we ? 32'(strb) : 32'd0);
    if (we) check("ldr_issue_ram_din", ram_din, wdata);
    @(negedge clk);  // RESP
    check("ldr_rsp_valid", 32'(ldr_rsp_valid), 32'd1);
    check("ldr_rdata", ldr_rdata, exp_rdata);
    rdata_o = ldr_rdata;
    @(negedge clk);
    check("ldr_rsp_one_cycle", 32'(ldr_rsp_valid), 32'd0);
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) ref_bytes[4*wa + b] = wdata[8*b +: 8];
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [31:0] rd;
  logic        er;
  int          order[$];
  int          hs_cyc[$];
  int          rsp_who[$];
  int          rsp_cyc[$];
  logic [31:0] arb_exp;

  initial begin
    rst = 1'b1;
    core_req_valid = 1'b0; core_we = 1'b0; core_funct3 = 3'd0;
    core_addr = 32'd0; core_wdata = 32'd0;
    ldr_req_valid = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = 32'd0; ldr_wstrb = 4'd0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_core_rsp_valid", 32'(core_rsp_valid), 32'd0);
    check("rst_core_rsp_err", 32'(core_rsp_err), 32'd0);
    check("rst_core_rdata", core_rdata, 32'd0);
    check("rst_ldr_rsp_valid", 32'(ldr_rsp_valid), 32'd0);
    check("rst_ldr_rdata", ldr_rdata, 32'd0);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_din", ram_din, 32'd0);
    core_req_valid = 1'b1; ldr_req_valid = 1'b1;
    #1;
    check("rst_core_ready", 32'(core_req_ready), 32'd0);
    check("rst_ldr_ready", 32'(ldr_req_ready), 32'd0);
    core_req_valid = 1'b0; ldr_req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Stores then reads
    core_txn(1'b1, 3'd2, 32'h10, 32'h11223344, rd, er);
    core_txn(1'b1, 3'd0, 32'h11, 32'h000000AA, rd, er);
    core_txn(1'b0, 3'd2, 32'h10, 32'd0, rd, er);
    check("plan_lw_0x10", rd, 32'h1122AA44);

    // Load extension
    core_txn(1'b1, 3'd2, 32'h20, 32'h80F07F81, rd, er);
    core_txn(1'b0, 3'd0, 32'h20, 32'd0, rd, er);
    check("plan_lb_0x20", rd, 32'hFFFFFF81);
    core_txn(1'b0, 3'd4, 32'h23, 32'd0, rd, er);
    check("plan_lbu_0x23", rd, 32'h00000080);
    core_txn(1'b0, 3'd1, 32'h22, 32'd0, rd, er);
    check("plan_lh_0x22", rd, 32'hFFFF80F0);
    core_txn(1'b0, 3'd5, 32'h20, 32'd0, rd, er);
    check("plan_lhu_0x20", rd, 32'h00007F81);

    // Rejected accesses
    core_txn(1'b0, 3'd1, 32'h21, 32'd0, rd, er);
    check("plan_err_misaligned", 32'(er), 32'd1);
    core_txn(1'b1, 3'd2, 32'h00008000, 32'hCAFEF00D, rd, er);
    check("plan_err_range", 32'(er), 32'd1);
    core_txn(1'b0, 3'd3, 32'h10, 32'd0, rd, er);
    check("plan_err_funct3", 32'(er), 32'd1);
    core_txn(1'b1, 3'd4, 32'h10, 32'hFFFFFFFF, rd, er);
    check("err_store_funct3", 32'(er), 32'd1);

    // Loader path
    ldr_txn(1'b1, 13'd5, 32'd0, 4'b1111, rd);
    ldr_txn(1'b1, 13'd5, 32'hDEADBEEF, 4'b0101, rd);
    ldr_txn(1'b0, 13'd5, 32'd0, 4'd0, rd);
    check("plan_ldr_strobe", rd, 32'h00AD00EF);

    // Reset during ISSUE
    core_txn(1'b1, 3'd2, 32'h0, 32'h12345678, rd, er);
    @(negedge clk);
    core_we = 1'b1; core_funct3 = 3'd2; core_addr = 32'h0; core_wdata = 32'hFFFFFFFF;
    core_req_valid = 1'b1;
    #1;
    check("rstmid_ready", 32'(core_req_ready), 32'd1);
    @(posedge clk); #1;
    core_req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_ram_en", 32'(ram_en), 32'd0);
    check("rstmid_ram_we", 32'(ram_we), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rstmid_no_rsp", 32'(core_rsp_valid), 32'd0);
      check("rstmid_no_ram", 32'(ram_en), 32'd0);
    end
    core_txn(1'b0, 3'd2, 32'h0, 32'd0, rd, er);
    check("rstmid_old_contents", rd, 32'h12345678);

    // Arbitration: both requesters continuously valid after reset
    apply_reset();
    arb_exp = model_word(4);
    @(negedge clk);
    core_we = 1'b0; core_funct3 = 3'd2; core_addr = 32'h10;
    ldr_we = 1'b0; ldr_addr = 13'd4;
    core_req_valid = 1'b1; ldr_req_valid = 1'b1;
    #1;
    for (int c = 0; c < 16; c++) begin
      check("arb_single_ready", 32'(core_req_ready && ldr_req_ready), 32'd0);
      if (core_rsp_valid) begin
        rsp_who.push_back(1); rsp_cyc.push_back(c);
        check("arb_core_rdata", core_rdata, arb_exp);
      end
      if (ldr_rsp_valid) begin
        rsp_who.push_back(0); rsp_cyc.push_back(c);
        check("arb_ldr_rdata", ldr_rdata, arb_exp);
      end
      if (order.size() < 4) begin
        if (core_req_ready) begin order.push_back(1); hs_cyc.push_back(c); end
        else if (ldr_req_ready) begin order.push_back(0); hs_cyc.push_back(c); end
      end
      @(posedge clk); #1;
      if (order.size() >= 4) begin core_req_valid = 1'b0; ldr_req_valid = 1'b0; end
      @(negedge clk); #1;
    end
    core_req_valid = 1'b0; ldr_req_valid = 1'b0;
    check("arb_grant_count", 32'(order.size()), 32'd4);
    check("arb_rsp_count", 32'(rsp_who.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < order.size()) check("arb_grant_order", 32'(order[i]), 32'((i % 2) == 0));
      if (i < rsp_who.size() && i < hs_cyc.size()) begin
        check("arb_rsp_owner", 32'(rsp_who[i]), 32'((i % 2) == 0));
        check("arb_rsp_latency", 32'(rsp_cyc[i]), 32'(hs_cyc[i] + 2));
      end
    end

    // Randomized mix of core and loader traffic
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        int unsigned sel;
        we  = 1'($urandom_range(0, 1));
        sel = $urandom_range(0, 9);
        if (sel < 8) begin
          if (we) f3 = 3'($urandom_range(0, 2));
          else begin
            sel = $urandom_range(0, 4);
            f3  = (sel > 2) ? 3'(sel + 1) : 3'(sel);
          end
        end else begin
          f3 = 3'($urandom_range(0, 7));
        end
        addr = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 255));
        core_txn(we, f3, addr, $urandom, rd, er);
      end else begin
        ldr_txn(1'($urandom_range(0, 1)), 13'($urandom_range(0, 63)), $urandom,
                4'($urandom_range(0, 15)), rd);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
